// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control: opcodes, functs, ALU ops, mux selects, states.
// Also defines the registered control-output bundle.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StRexec  = 4'd6,
      StRwb    = 4'd7,
      StBeq    = 4'd8,
      StIexec  = 4'd9,
      StIwb    = 4'd10,
      StJump   = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_op;
      logic       ext_zero;
   } ctl_t;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct decoder: maps funct to the ALU operation and flags unsupported functs.
// Purely combinational; the control FSM uses it directly while in REXEC.
module mips_alu_dec
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_op,
   output logic       valid
);

   always_comb begin
      alu_op = ALU_ADD;
      valid  = 1'b1;
      case (funct)
         FN_ADD:  alu_op = ALU_ADD;
         FN_SUB:  alu_op = ALU_SUB;
         FN_AND:  alu_op = ALU_AND;
         FN_OR:   alu_op = ALU_OR;
         FN_SLT:  alu_op = ALU_SLT;
         default: valid  = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM with registered Moore outputs.
// Optional MC_CTRL_IMM_LOGIC_EN adds andi/ori/slti to the immediate-execute path.
module mips_mc_control
   import mips_pkg::*;
#(
   parameter int unsigned STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   output logic               pc_write,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mem_to_reg,
   output logic               reg_dst,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         pc_src,
   output logic [2:0]         alu_op,
   output logic               ext_zero,
   output logic               illegal,
   output logic [STATE_W-1:0] state_o
);

   state_t     state_q, state_d;
   ctl_t       ctl_q;
   logic [2:0] dec_op;
   logic       dec_valid;

   mips_alu_dec u_alu_dec (
      .funct  (funct),
      .alu_op (dec_op),
      .valid  (dec_valid)
   );

   // Outputs for the state being entered; registered so they are a pure function of state_q.
   function automatic ctl_t state_ctl(state_t s, logic [5:0] op);
      ctl_t c;
      c = '0;
      case (s)
         StFetch: begin
            c.mem_read  = 1'b1;
            c.ir_write  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.pc_write  = 1'b1;
         end
         StDecode: c.alu_src_b = SRCB_IMM_SH2;
         StMemAdr: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         StMemRd: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         StMemWb: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         StMemWr: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         StRexec: c.alu_src_a = 1'b1;
         StRwb: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         StBeq: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = ALU_SUB;
            c.pc_src    = PCSRC_ALUOUT;
         end
         StIexec: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
`ifdef MC_CTRL_IMM_LOGIC_EN
            case (op)
               OP_ANDI: c.alu_op = ALU_AND;
               OP_ORI:  c.alu_op = ALU_OR;
               OP_SLTI: c.alu_op = ALU_SLT;
               default: c.alu_op = ALU_ADD;
            endcase
            c.ext_zero = (op == OP_ANDI) || (op == OP_ORI);
`else
            c.alu_op = (op == OP_ADDI) ? ALU_ADD : ALU_ADD;
`endif
         end
         StIwb: c.reg_write = 1'b1;
         StJump: begin
            c.pc_src   = PCSRC_JUMP;
            c.pc_write = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:  state_d = StDecode;
         StDecode: begin
            case (opcode)
               OP_LW, OP_SW: state_d = StMemAdr;
               OP_RTYPE:     state_d = StRexec;
               OP_BEQ:       state_d = StBeq;
               OP_ADDI:      state_d = StIexec;
               OP_J:         state_d = StJump;
`ifdef MC_CTRL_IMM_LOGIC_EN
               OP_ANDI, OP_ORI, OP_SLTI: state_d = StIexec;
`endif
               default:      state_d = StFetch;
            endcase
         end
         StMemAdr: state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
         StMemRd:  state_d = StMemWb;
         StRexec:  state_d = dec_valid ? StRwb : StFetch;
         StIexec:  state_d = StIwb;
         default:  state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFetch;
         ctl_q   <= state_ctl(StFetch, opcode);
      end else begin
         state_q <= state_d;
         ctl_q   <= state_ctl(state_d, opcode);
      end
   end

   // DECODE falling back to FETCH means the opcode was not recognised.
   assign illegal = ((state_q == StDecode) && (state_d == StFetch)) ||
                    ((state_q == StRexec) && !dec_valid);

   assign pc_write   = ctl_q.pc_write | ((state_q == StBeq) & zero);
   assign alu_op     = (state_q == StRexec) ? dec_op : ctl_q.alu_op;
   assign i_or_d     = ctl_q.i_or_d;
   assign mem_read   = ctl_q.mem_read;
   assign mem_write  = ctl_q.mem_write;
   assign ir_write   = ctl_q.ir_write;
   assign mem_to_reg = ctl_q.mem_to_reg;
   assign reg_dst    = ctl_q.reg_dst;
   assign reg_write  = ctl_q.reg_write;
   assign alu_src_a  = ctl_q.alu_src_a;
   assign alu_src_b  = ctl_q.alu_src_b;
   assign pc_src     = ctl_q.pc_src;
   assign ext_zero   = ctl_q.ext_zero;
   assign state_o    = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed table-driven bench for mips_mc_control, plus per-instruction latency sequences.
// Expectations follow MC_CTRL_IMM_LOGIC_EN when the macro is defined.
module tb_mips_mc_control;

   logic       clk = 1'b0;
   logic       rst, zero;
   logic [5:0] opcode, funct;
   logic       pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst;
   logic       reg_write, alu_src_a, ext_zero, illegal;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_op;
   logic [3:0] state_o;

   always #5 clk = ~clk;

   mips_mc_control #(.STATE_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .pc_write   (pc_write),
      .i_or_d     (i_or_d),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .mem_to_reg (mem_to_reg),
      .reg_dst    (reg_dst),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .pc_src     (pc_src),
      .alu_op     (alu_op),
      .ext_zero   (ext_zero),
      .illegal    (illegal),
      .state_o    (state_o)
   );

   // {pc_write,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,alu_src_a,
   //  alu_src_b,pc_src,alu_op,ext_zero,illegal}
   wire [18:0] outs = {pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                       reg_write, alu_src_a, alu_src_b, pc_src, alu_op, ext_zero, illegal};

   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
   localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_REXEC = 4'd6, S_RWB = 4'd7;
   localparam logic [3:0] S_BEQ = 4'd8, S_IEXEC = 4'd9, S_IWB = 4'd10, S_JUMP = 4'd11;

   localparam logic [18:0] E_FETCH    = {9'b101010000, 2'b01, 2'b00, 3'b000, 2'b00};
   localparam logic [18:0] E_DECODE   = {9'b000000000, 2'b11, 2'b00, 3'b000, 2'b00};
   localparam logic [18:0] E_DEC_ILL  = {9'b000000000, 2'b11, 2'b00, 3'b000, 2'b01};
   localparam logic [18:0] E_MEMADR   = {9'b000000001, 2'b10, 2'b00, 3'b000, 2'b00};
   localparam logic [18:0] E_MEMRD    = {9'b011000000, 9'b0};
   localparam logic [18:0] E_MEMWB    = {9'b000001010, 9'b0};
   localparam logic [18:0] E_MEMWR    = {9'b010100000, 9'b0};
   localparam logic [18:0] E_RWB      = {9'b000000110, 9'b0};
   localparam logic [18:0] E_IWB      = {9'b000000010, 9'b0};
   localparam logic [18:0] E_JUMP     = {9'b100000000, 2'b00, 2'b10, 3'b000, 2'b00};

   function automatic logic [18:0] e_rexec(logic [2:0] op, logic il);
      return {9'b000000001, 2'b00, 2'b00, op, 1'b0, il};
   endfunction

   function automatic logic [18:0] e_beq(logic z);
      return {z, 8'b00000001, 2'b00, 2'b01, 3'b001, 2'b00};
   endfunction

   function automatic logic [18:0] e_iexec(logic [2:0] op, logic ez);
      return {9'b000000001, 2'b10, 2'b00, op, ez, 1'b0};
   endfunction

   typedef struct {
      logic       r;
      logic [5:0] opc;
      logic [5:0] fn;
      logic       z;
      logic [3:0] st;
      logic [18:0] out;
   } vec_t;

   typedef struct {
      logic [5:0] opc;
      logic [5:0] fn;
      logic       z;
      int         cycles;
   } lat_t;

   vec_t vecs[$];
   lat_t lats[$];
   int   errors = 0;
   int   checks = 0;

   task automatic add(logic r, logic [5:0] opc, logic [5:0] fn, logic z, logic [3:0] st,
                      logic [18:0] out);
      vecs.push_back('{r: r, opc: opc, fn: fn, z: z, st: st, out: out});
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0;

      // Reset held for two edges, then lw.
      add(1, 6'h23, 6'h00, 0, S_FETCH,  E_FETCH);
      add(0, 6'h23, 6'h00, 0, S_FETCH,  E_FETCH);
      add(0, 6'h23, 6'h00, 0, S_DECODE, E_DECODE);
      add(0, 6'h23, 6'h00, 0, S_MEMADR, E_MEMADR);
      add(0, 6'h23, 6'h00, 0, S_MEMRD,  E_MEMRD);
      add(0, 6'h23, 6'h00, 0, S_MEMWB,  E_MEMWB);
      // sw with reset asserted while in MEMWR
      add(0, 6'h2B, 6'h00, 0, S_FETCH,  E_FETCH);
      add(0, 6'h2B, 6'h00, 0, S_DECODE, E_DECODE);
      add(0, 6'h2B, 6'h00, 0, S_MEMADR, E_MEMADR);
      add(1, 6'h2B, 6'h00, 0, S_MEMWR,  E_MEMWR);
      // R-type sub, slt, unknown funct
      add(0, 6'h00, 6'h22, 0, S_FETCH,  E_FETCH);
      add(0, 6'h00, 6'h22, 0, S_DECODE, E_DECODE);
      add(0, 6'h00, 6'h22, 0, S_REXEC,  e_rexec(3'b001, 1'b0));
      add(0, 6'h00, 6'h22, 0, S_RWB,    E_RWB);
      add(0, 6'h00, 6'h2A, 0, S_FETCH,  E_FETCH);
      add(0, 6'h00, 6'h2A, 0, S_DECODE, E_DECODE);
      add(0, 6'h00, 6'h2A, 0, S_REXEC,  e_rexec(3'b100, 1'b0));
      add(0, 6'h00, 6'h2A, 0, S_RWB,    E_RWB);
      add(0, 6'h00, 6'h27, 0, S_FETCH,  E_FETCH);
      add(0, 6'h00, 6'h27, 0, S_DECODE, E_DECODE);
      add(0, 6'h00, 6'h27, 0, S_REXEC,  e_rexec(3'b000, 1'b1));
      // beq taken and not taken
      add(0, 6'h04, 6'h00, 1, S_FETCH,  E_FETCH);
      add(0, 6'h04, 6'h00, 1, S_DECODE, E_DECODE);
      add(0, 6'h04, 6'h00, 1, S_BEQ,    e_beq(1'b1));
      add(0, 6'h04, 6'h00, 0, S_FETCH,  E_FETCH);
      add(0, 6'h04, 6'h00, 0, S_DECODE, E_DECODE);
      add(0, 6'h04, 6'h00, 0, S_BEQ,    e_beq(1'b0));
      // addi, j
      add(0, 6'h08, 6'h00, 0, S_FETCH,  E_FETCH);
      add(0, 6'h08, 6'h00, 0, S_DECODE, E_DECODE);
      add(0, 6'h08, 6'h00, 0, S_IEXEC,  e_iexec(3'b000, 1'b0));
      add(0, 6'h08, 6'h00, 0, S_IWB,    E_IWB);
      add(0, 6'h02, 6'h00, 0, S_FETCH,  E_FETCH);
      add(0, 6'h02, 6'h00, 0, S_DECODE, E_DECODE);
      add(0, 6'h02, 6'h00, 0, S_JUMP,   E_JUMP);
      // ori
      add(0, 6'h0D, 6'h00, 0, S_FETCH,  E_FETCH);
`ifdef MC_CTRL_IMM_LOGIC_EN
      add(0, 6'h0D, 6'h00, 0, S_DECODE, E_DECODE);
      add(0, 6'h0D, 6'h00, 0, S_IEXEC,  e_iexec(3'b011, 1'b1));
      add(0, 6'h0D, 6'h00, 0, S_IWB,    E_IWB);
      add(0, 6'h0C, 6'h00, 0, S_FETCH,  E_FETCH);
      add(0, 6'h0C, 6'h00, 0, S_DECODE, E_DECODE);
      add(0, 6'h0C, 6'h00, 0, S_IEXEC,  e_iexec(3'b010, 1'b1));
      add(0, 6'h0C, 6'h00, 0, S_IWB,    E_IWB);
`else
      add(0, 6'h0D, 6'h00, 0, S_DECODE, E_DEC_ILL);
`endif
      // unknown opcode
      add(0, 6'h3F, 6'h00, 0, S_FETCH,  E_FETCH);
      add(0, 6'h3F, 6'h00, 0, S_DECODE, E_DEC_ILL);
      add(0, 6'h3F, 6'h00, 0, S_FETCH,  E_FETCH);

      lats.push_back('{opc: 6'h23, fn: 6'h00, z: 1'b0, cycles: 5});
      lats.push_back('{opc: 6'h2B, fn: 6'h00, z: 1'b0, cycles: 4});
      lats.push_back('{opc: 6'h00, fn: 6'h20, z: 1'b0, cycles: 4});
      lats.push_back('{opc: 6'h00, fn: 6'h25, z: 1'b0, cycles: 4});
      lats.push_back('{opc: 6'h00, fn: 6'h3F, z: 1'b0, cycles: 3});
      lats.push_back('{opc: 6'h08, fn: 6'h00, z: 1'b0, cycles: 4});
      lats.push_back('{opc: 6'h04, fn: 6'h00, z: 1'b1, cycles: 3});
      lats.push_back('{opc: 6'h04, fn: 6'h00, z: 1'b0, cycles: 3});
      lats.push_back('{opc: 6'h02, fn: 6'h00, z: 1'b0, cycles: 3});
      lats.push_back('{opc: 6'h15, fn: 6'h00, z: 1'b0, cycles: 2});
`ifdef MC_CTRL_IMM_LOGIC_EN
      lats.push_back('{opc: 6'h0A, fn: 6'h00, z: 1'b0, cycles: 4});
`else
      lats.push_back('{opc: 6'h0A, fn: 6'h00, z: 1'b0, cycles: 2});
`endif

      @(posedge clk);
      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].r; opcode = vecs[i].opc; funct = vecs[i].fn; zero = vecs[i].z;
         #1;
         check($sformatf("vec%0d state", i), 32'(state_o), 32'(vecs[i].st));
         check($sformatf("vec%0d outputs", i), 32'(outs), 32'(vecs[i].out));
      end

      // Latency from FETCH back to FETCH, with output exclusivity checked every cycle.
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      foreach (lats[i]) begin
         int n;
         opcode = lats[i].opc; funct = lats[i].fn; zero = lats[i].z;
         n = 0;
         do begin
            @(posedge clk);
            n++;
            #1;
            check($sformatf("lat%0d rd/wr excl", i), 32'(mem_read & mem_write), 32'd0);
            if (state_o != S_FETCH)
               check($sformatf("lat%0d rw/pw excl", i), 32'(reg_write & pc_write), 32'd0);
         end while (state_o != S_FETCH && n < 20);
         check($sformatf("lat%0d cycles op=%0h", i, lats[i].opc), 32'(n), 32'(lats[i].cycles));
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
